data_mem_responder: RTL

//  Slave end of the pipeline data-memory port: accepts addr_mem/wdata_mem/write_mem from S3 MEMWRT,

---
 rtl/kaiser_mem_pkg.sv | 37 +++
 rtl/mmio_timer.sv | 59 +++++
 rtl/data_mem_responder.sv | 98 +++++++++
 3 files changed

// File: rtl/kaiser_mem_pkg.sv
// Shared address map, select decode and reset constants for the data-memory responder.
package kaiser_mem_pkg;

  localparam int SEL_BIT = 8;
  localparam int IO_W    = 10;

  localparam logic [8:0] ADDR_SW   = 9'h100;
  localparam logic [8:0] ADDR_LED  = 9'h101;
  localparam logic [8:0] ADDR_TCNT = 9'h102;
  localparam logic [8:0] ADDR_TCMP = 9'h103;
  localparam logic [8:0] ADDR_STAT = 9'h104;

  localparam logic [15:0] TCMP_RST = 16'hFFFF;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_SW,
    SEL_LED,
    SEL_TCNT,
    SEL_TCMP,
    SEL_STAT,
    SEL_NONE
  } mem_sel_e;

  function automatic mem_sel_e decode_addr(input logic [8:0] a);
    if (!a[SEL_BIT]) return SEL_RAM;
    case (a)
      ADDR_SW:   return SEL_SW;
      ADDR_LED:  return SEL_LED;
      ADDR_TCNT: return SEL_TCNT;
      ADDR_TCMP: return SEL_TCMP;
      ADDR_STAT: return SEL_STAT;
      default:   return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Prescaled free-running counter with a compare register and a sticky match flag.
module mmio_timer
  import kaiser_mem_pkg::*;
#(
  parameter int W         = 16,
  parameter int TIMER_DIV = 50
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tcnt_wr_i,
  input  logic         tcmp_wr_i,
  input  logic         stat_clr_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] tcnt_o,
  output logic [W-1:0] tcmp_o,
  output logic         match_o,
  output logic         match_d_o
);

  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(TIMER_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  tcnt_q, tcnt_d, tcnt_inc;
  logic [W-1:0]  tcmp_q, tcmp_d;
  logic          match_q, match_d;
  logic          tick, hit;

  // A count write suppresses both the increment and the compare; a new match beats a clear.
  always_comb begin
    tick     = (presc_q == PRESC_TC);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    tcnt_inc = tcnt_q + 1'b1;
    hit      = tick & ~tcnt_wr_i & (tcnt_inc == tcmp_q);
    tcnt_d   = tcnt_wr_i ? '0 : (tick ? tcnt_inc : tcnt_q);
    tcmp_d   = tcmp_wr_i ? wdata_i : tcmp_q;
    match_d  = hit | (match_q & ~stat_clr_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      tcnt_q  <= '0;
      tcmp_q  <= W'(TCMP_RST);
      match_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
      tcmp_q  <= tcmp_d;
      match_q <= match_d;
    end
  end

  assign tcnt_o    = tcnt_q;
  assign tcmp_o    = tcmp_q;
  assign match_o   = match_q;
  assign match_d_o = match_d;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory slave: 256-word RAM plus switch/LED/timer MMIO, registered read data one cycle after address.
module data_mem_responder
  import kaiser_mem_pkg::*;
#(
  parameter int    DATA_W    = 16,
  parameter int    ADDR_W    = 9,
  parameter int    RAM_WORDS = 256,
  parameter int    TIMER_DIV = 50,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_mem,
  input  logic [DATA_W-1:0] wdata_mem,
  input  logic              write_mem,
  output logic [DATA_W-1:0] rdata_mem,
  input  logic [IO_W-1:0]   sw_in,
  output logic [IO_W-1:0]   led_out,
  output logic              tmr_match
);

  localparam int RAM_AW = $clog2(RAM_WORDS);

  logic [DATA_W-1:0] ram_q [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;
  mem_sel_e          sel;
  logic              ram_we, led_we, tcnt_wr, tcmp_wr, stat_clr;
  logic [IO_W-1:0]   led_q, led_d;
  logic [IO_W-1:0]   sw_meta_q, sw_sync_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] tcnt, tcmp;
  logic              match, match_next;

  // Stores are gated by rst so a store presented during reset never lands.
  always_comb begin
    sel      = decode_addr(addr_mem);
    ram_idx  = addr_mem[RAM_AW-1:0];
    ram_we   = write_mem & ~rst & (sel == SEL_RAM);
    led_we   = write_mem & (sel == SEL_LED);
    tcnt_wr  = write_mem & (sel == SEL_TCNT);
    tcmp_wr  = write_mem & (sel == SEL_TCMP);
    stat_clr = write_mem & (sel == SEL_STAT) & wdata_mem[0];
    led_d    = led_we ? wdata_mem[IO_W-1:0] : led_q;
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= wdata_mem;
  end

  mmio_timer #(
    .W         (DATA_W),
    .TIMER_DIV (TIMER_DIV)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .tcnt_wr_i  (tcnt_wr),
    .tcmp_wr_i  (tcmp_wr),
    .stat_clr_i (stat_clr),
    .wdata_i    (wdata_mem),
    .tcnt_o     (tcnt),
    .tcmp_o     (tcmp),
    .match_o    (match),
    .match_d_o  (match_next)
  );

  // Write-first read mux: a store to the addressed location returns the value being written.
  always_comb begin
    rdata_d = '0;
    case (sel)
      SEL_RAM:  rdata_d = write_mem ? wdata_mem : ram_q[ram_idx];
      SEL_SW:   rdata_d = {{(DATA_W-IO_W){1'b0}}, sw_sync_q};
      SEL_LED:  rdata_d = {{(DATA_W-IO_W){1'b0}}, led_d};
      SEL_TCNT: rdata_d = tcnt_wr ? '0 : tcnt;
      SEL_TCMP: rdata_d = tcmp_wr ? wdata_mem : tcmp;
      SEL_STAT: rdata_d = {{(DATA_W-1){1'b0}}, (write_mem ? match_next : match)};
      default:  rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q   <= '0;
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      sw_meta_q <= sw_in;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign rdata_mem = rdata_q;
  assign led_out   = led_q;
  assign tmr_match = match;

endmodule
